adder_arbiter: RTL and testbench

ADDER_ARBITER -- requirements
Module: adder_arbiter

---
 rtl/adder_pkg.sv | 21 ++
 rtl/add16.sv | 14 +
 rtl/adder_arbiter.sv | 133 +++++++++++++
 tb/tb_adder_arbiter.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared constants, FSM encoding and the two-requester grant rule for adder_arbiter.
package adder_pkg;

  localparam int DATA_W = 32;
  localparam int HALF_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Returns the winning requester index; last=1 means requester 1 won most recently.
  function automatic logic arb_pick(input logic v0, input logic v1,
                                    input logic last, input logic fixed);
    if (v0 && v1) return fixed ? 1'b0 : ~last;
    return v1 & ~v0;
  endfunction

endpackage

// File: rtl/add16.sv
// 16-bit ripple adder with carry in/out, reused for both operand halves.
module add16
  import adder_pkg::*;
(
  input  logic [HALF_W-1:0] a,
  input  logic [HALF_W-1:0] b,
  input  logic              carry_in,
  output logic [HALF_W-1:0] sum,
  output logic              carry_out
);

  assign {carry_out, sum} = {1'b0, a} + {1'b0, b} + {{HALF_W{1'b0}}, carry_in};

endmodule

// File: rtl/adder_arbiter.sv
// Two-requester arbiter feeding a 32-bit add computed over two cycles on one add16.
module adder_arbiter
  import adder_pkg::*;
#(
  parameter bit PRIO_FIXED = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_sum,
  output logic              rsp_overflow
);

  state_t              r_state, w_next;
  logic                w_any, w_gnt_id, w_accept;
  logic [DATA_W-1:0]   w_sel_a, w_sel_b;
  logic [HALF_W-1:0]   r_a_hi, r_b_hi;
  logic                r_id, r_last, r_carry;
  logic [HALF_W-1:0]   r_op_a, r_op_b, r_sum_lo;
  logic [HALF_W-1:0]   w_add_sum;
  logic                w_add_cin, w_add_cout;
  logic [DATA_W-1:0]   r_rsp_sum;
  logic                r_rsp_ovf, r_rsp_id;

  assign w_any    = req0_valid | req1_valid;
  assign w_gnt_id = arb_pick(req0_valid, req1_valid, r_last, PRIO_FIXED);
  assign w_accept = (r_state == ST_IDLE) && w_any;
  assign w_sel_a  = w_gnt_id ? req1_a : req0_a;
  assign w_sel_b  = w_gnt_id ? req1_b : req0_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_any) w_next = ST_LOW;
      ST_LOW:  w_next = ST_HIGH;
      ST_HIGH: w_next = ST_DONE;
      ST_DONE: if (rsp_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Ready is combinational from the grant, so it must also be gated by reset.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp_valid  = (r_state == ST_DONE);
    if (rst_n && w_accept) begin
      req0_ready = ~w_gnt_id;
      req1_ready =  w_gnt_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b1;
      r_id   <= 1'b0;
      r_a_hi <= '0;
      r_b_hi <= '0;
    end else if (w_accept) begin
      r_last <= w_gnt_id;
      r_id   <= w_gnt_id;
      r_a_hi <= w_sel_a[DATA_W-1:HALF_W];
      r_b_hi <= w_sel_b[DATA_W-1:HALF_W];
    end
  end

  // Operand mux register: low halves load on acceptance, high halves during LOW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_a <= '0;
      r_op_b <= '0;
    end else if (w_accept) begin
      r_op_a <= w_sel_a[HALF_W-1:0];
      r_op_b <= w_sel_b[HALF_W-1:0];
    end else if (r_state == ST_LOW) begin
      r_op_a <= r_a_hi;
      r_op_b <= r_b_hi;
    end
  end

  assign w_add_cin = (r_state == ST_HIGH) & r_carry;

  add16 u_add16 (
    .a         (r_op_a),
    .b         (r_op_b),
    .carry_in  (w_add_cin),
    .sum       (w_add_sum),
    .carry_out (w_add_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum_lo <= '0;
      r_carry  <= 1'b0;
    end else if (r_state == ST_LOW) begin
      r_sum_lo <= w_add_sum;
      r_carry  <= w_add_cout;
    end
  end

  // Visible result only moves on the HIGH->DONE edge, so it stays put while waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_sum <= '0;
      r_rsp_ovf <= 1'b0;
      r_rsp_id  <= 1'b0;
    end else if (r_state == ST_HIGH) begin
      r_rsp_sum <= {w_add_sum, r_sum_lo};
      r_rsp_ovf <= w_add_cout;
      r_rsp_id  <= r_id;
    end
  end

  assign rsp_sum      = r_rsp_sum;
  assign rsp_overflow = r_rsp_ovf;
  assign rsp_id       = r_rsp_id;

endmodule

// File: tb/tb_adder_arbiter.sv
// Random and directed stimulus on round-robin and fixed-priority instances against a transaction model.
module tb_adder_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        v0 = 1'b0, v1 = 1'b0, rr = 1'b0;
  logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;

  logic        rdy0_r, rdy1_r, vld_r, id_r, ovf_r;
  logic        rdy0_f, rdy1_f, vld_f, id_f, ovf_f;
  logic [31:0] sum_r, sum_f;

  logic        o_rdy0[2], o_rdy1[2], o_vld[2], o_id[2], o_ovf[2];
  logic [31:0] o_sum[2];

  int n_chk = 0, n_bad = 0;

  // Model: busy/latency countdown after acceptance, pending response, last visible result.
  bit          m_busy[2], m_pend[2], m_last[2], m_oid[2], m_nid[2];
  int          m_lat[2];
  logic [32:0] m_out[2], m_nx[2];
  bit          log_en = 1'b0;
  int          g_rr[$], g_fx[$];

  always #5 clk = ~clk;

  adder_arbiter #(.PRIO_FIXED(1'b0)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0), .req0_ready(rdy0_r), .req0_a(a0), .req0_b(b0),
    .req1_valid(v1), .req1_ready(rdy1_r), .req1_a(a1), .req1_b(b1),
    .rsp_valid(vld_r), .rsp_ready(rr), .rsp_id(id_r), .rsp_sum(sum_r), .rsp_overflow(ovf_r)
  );

  adder_arbiter #(.PRIO_FIXED(1'b1)) u_fx (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0), .req0_ready(rdy0_f), .req0_a(a0), .req0_b(b0),
    .req1_valid(v1), .req1_ready(rdy1_f), .req1_a(a1), .req1_b(b1),
    .rsp_valid(vld_f), .rsp_ready(rr), .rsp_id(id_f), .rsp_sum(sum_f), .rsp_overflow(ovf_f)
  );

  always_comb begin
    o_rdy0[0] = rdy0_r; o_rdy0[1] = rdy0_f;
    o_rdy1[0] = rdy1_r; o_rdy1[1] = rdy1_f;
    o_vld[0]  = vld_r;  o_vld[1]  = vld_f;
    o_id[0]   = id_r;   o_id[1]   = id_f;
    o_ovf[0]  = ovf_r;  o_ovf[1]  = ovf_f;
    o_sum[0]  = sum_r;  o_sum[1]  = sum_f;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    for (int d = 0; d < 2; d++) begin
      m_busy[d] = 1'b0; m_pend[d] = 1'b0; m_last[d] = 1'b1;
      m_lat[d] = 0; m_out[d] = '0; m_oid[d] = 1'b0;
    end
  endtask

  task automatic chk_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s_rdy0[%0d]", tag, d), 64'(o_rdy0[d]), 64'(0));
      chk($sformatf("%s_rdy1[%0d]", tag, d), 64'(o_rdy1[d]), 64'(0));
      chk($sformatf("%s_vld[%0d]", tag, d),  64'(o_vld[d]),  64'(0));
      chk($sformatf("%s_sum[%0d]", tag, d),  64'(o_sum[d]),  64'(0));
      chk($sformatf("%s_ovf[%0d]", tag, d),  64'(o_ovf[d]),  64'(0));
      chk($sformatf("%s_id[%0d]", tag, d),   64'(o_id[d]),   64'(0));
    end
  endtask

  // One clock: drive at negedge, compare against the model, then advance the model past the next posedge.
  task automatic step(input bit iv0, input logic [31:0] ia0, input logic [31:0] ib0,
                      input bit iv1, input logic [31:0] ia1, input logic [31:0] ib1,
                      input bit irr);
    bit idle, w, any;
    @(negedge clk);
    v0 = iv0; a0 = ia0; b0 = ib0;
    v1 = iv1; a1 = ia1; b1 = ib1;
    rr = irr;
    #1;
    any = iv0 | iv1;
    for (int d = 0; d < 2; d++) begin
      idle = !m_busy[d] && !m_pend[d];
      if (iv0 && iv1) w = (d == 1) ? 1'b0 : !m_last[d];
      else            w = iv1;
      chk($sformatf("ready0[%0d]", d),    64'(o_rdy0[d]), 64'(idle && any && !w));
      chk($sformatf("ready1[%0d]", d),    64'(o_rdy1[d]), 64'(idle && any && w));
      chk($sformatf("rsp_valid[%0d]", d), 64'(o_vld[d]),  64'(m_pend[d]));
      chk($sformatf("rsp_sum[%0d]", d),   64'(o_sum[d]),  64'(m_out[d][31:0]));
      chk($sformatf("rsp_ovf[%0d]", d),   64'(o_ovf[d]),  64'(m_out[d][32]));
      chk($sformatf("rsp_id[%0d]", d),    64'(o_id[d]),   64'(m_oid[d]));
      if (log_en) begin
        if (o_rdy0[d]) begin if (d == 0) g_rr.push_back(0); else g_fx.push_back(0); end
        if (o_rdy1[d]) begin if (d == 0) g_rr.push_back(1); else g_fx.push_back(1); end
      end
      if (m_pend[d]) begin
        if (irr) m_pend[d] = 1'b0;
      end else if (m_busy[d]) begin
        m_lat[d]--;
        if (m_lat[d] == 0) begin
          m_busy[d] = 1'b0; m_pend[d] = 1'b1;
          m_out[d] = m_nx[d]; m_oid[d] = m_nid[d];
        end
      end else if (any) begin
        m_busy[d] = 1'b1; m_lat[d] = 2;
        m_nid[d]  = w; m_last[d] = w;
        m_nx[d]   = w ? ({1'b0, ia1} + {1'b0, ib1}) : ({1'b0, ia0} + {1'b0, ib0});
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 5; i++) step(1'b0, $urandom(), $urandom(), 1'b0, $urandom(), $urandom(), 1'b1);
  endtask

  // Single request from one requester; result must be visible exactly three cycles after its ready.
  task automatic run_op(input bit id, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] es, input bit eo, input string tag);
    step(!id, a, b, id, a, b, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, $urandom(), $urandom(), 1'b0, $urandom(), $urandom(), 1'b0);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s_vld[%0d]", tag, d), 64'(o_vld[d]), 64'(1));
      chk($sformatf("%s_sum[%0d]", tag, d), 64'(o_sum[d]), 64'(es));
      chk($sformatf("%s_ovf[%0d]", tag, d), 64'(o_ovf[d]), 64'(eo));
      chk($sformatf("%s_id[%0d]", tag, d),  64'(o_id[d]),  64'(id));
    end
    drain();
  endtask

  initial begin
    m_reset();
    v0 = 1'b1; v1 = 1'b1;
    #3;
    chk_zero("reset");
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Both requesters valid continuously from reset.
    log_en = 1'b1;
    for (int i = 0; i < 16; i++) step(1'b1, $urandom(), $urandom(), 1'b1, $urandom(), $urandom(), 1'b1);
    log_en = 1'b0;
    chk("rr_grants", 64'(g_rr.size()), 64'(4));
    chk("fx_grants", 64'(g_fx.size()), 64'(4));
    for (int i = 0; i < 4; i++) begin
      if (i < g_rr.size()) chk($sformatf("rr_order%0d", i), 64'(g_rr[i]), 64'(i % 2));
      if (i < g_fx.size()) chk($sformatf("fx_order%0d", i), 64'(g_fx[i]), 64'(0));
    end
    drain();

    run_op(1'b0, 32'h0000FFFF, 32'h00000001, 32'h00010000, 1'b0, "carry16");
    run_op(1'b1, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, "wrap");
    run_op(1'b1, 32'h12345678, 32'h11111111, 32'h23456789, 1'b0, "plain");

    // Backpressure in DONE while both requesters keep asking.
    for (int i = 0; i < 9; i++) step(1'b1, $urandom(), $urandom(), 1'b1, $urandom(), $urandom(), 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, $urandom(), $urandom(), 1'b1, $urandom(), $urandom(), 1'b1);
    drain();

    // Reset pulse while the upper half is being computed.
    step(1'b1, 32'hDEADBEEF, 32'h01234567, 1'b0, $urandom(), $urandom(), 1'b0);
    step(1'b1, $urandom(), $urandom(), 1'b1, $urandom(), $urandom(), 1'b0);
    step(1'b1, $urandom(), $urandom(), 1'b1, $urandom(), $urandom(), 1'b0);
    #1 rst_n = 1'b0;
    #1 chk_zero("midreset");
    m_reset();
    v0 = 1'b0; v1 = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    run_op(1'b0, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, "after_rst");

    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), $urandom(), $urandom(),
           1'($urandom_range(0, 1)), $urandom(), $urandom(),
           1'($urandom_range(0, 3) != 0));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
